// File: rtl/nnrv_mem_stage.sv
// rtl/nnrv_mem_stage.sv - nnrv memory stage: single-beat RAM req/ack, load alignment/extension, writeback.
// Optional ACCESS timeout abort enabled by defining NNRV_MEM_TIMEOUT_EN.
module nnrv_mem_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ex_rd_en,
    input  logic [4:0]            i_ex_rd,
    input  logic [XLEN-1:0]       i_ex_rd_reg,
    input  logic                  i_ex_ram_rd_en,
    input  logic                  i_ex_ram_wr_en,
    input  logic [XLEN-1:0]       i_ex_ram_addr,
    input  logic [XLEN-1:0]       i_ex_ram_data,
    input  logic [3:0]            i_ex_ram_mask,
    input  logic                  i_ex_sign,
    output logic                  o_ex_stall,
    output logic                  o_ram_req,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [XLEN-1:0]       o_ram_wdata,
    output logic [3:0]            o_ram_be,
    input  logic                  i_ram_ack,
    input  logic [XLEN-1:0]       i_ram_rdata,
    output logic                  o_wb_rd_en,
    output logic [4:0]            o_wb_rd,
    output logic [XLEN-1:0]       o_wb_rd_reg,
    output logic                  o_id_rd_ready,
    output logic                  o_bus_err
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state;
    logic                  lat_we;
    logic                  lat_sign;
    logic                  lat_rd_en;
    logic [4:0]            lat_rd;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [XLEN-1:0]       lat_data;
    logic [3:0]            lat_mask;

    logic                  mem_op;
    logic                  req_hit;
    logic                  in_access;
    logic                  timeout_hit;
    logic                  bus_err;
    logic [1:0]            lane;
    logic [15:0]           shifted;
    logic [XLEN-1:0]       load_val;
    logic                  unused_bits;

    assign mem_op    = i_ex_ram_rd_en | i_ex_ram_wr_en;
    assign req_hit   = mem_op && (i_ex_ram_mask != 4'b0000);
    assign in_access = (state == ACCESS);

`ifdef NNRV_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tcnt;
    assign timeout_hit = in_access && !i_ram_ack && (tcnt == CW'(TIMEOUT - 1));
    assign o_bus_err   = bus_err;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
    assign o_bus_err   = 1'b0;
`endif

    assign o_ex_stall    = (!in_access && req_hit) || (in_access && !i_ram_ack && !timeout_hit);
    assign o_ram_req     = in_access;
    assign o_ram_we      = lat_we;
    assign o_ram_addr    = lat_addr;
    assign o_ram_wdata   = lat_data;
    assign o_ram_be      = lat_mask;
    assign o_id_rd_ready = o_wb_rd_en;
    assign unused_bits   = ^{i_ex_ram_addr[XLEN-1:ADDR_WIDTH+2], i_ex_ram_addr[1:0], TIMEOUT[0], bus_err};

    // Load field sits at the lowest enabled lane; odd masks return the whole word.
    always_comb begin
        lane = 2'd0;
        casez (lat_mask)
            4'b???1: lane = 2'd0;
            4'b??10: lane = 2'd1;
            4'b?100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: lane = 2'd0;
        endcase
        shifted  = 16'(i_ram_rdata >> {lane, 3'b000});
        load_val = i_ram_rdata;
        case (lat_mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000:
                load_val = {{(XLEN-8){lat_sign & shifted[7]}}, shifted[7:0]};
            4'b0011, 4'b0110, 4'b1100:
                load_val = {{(XLEN-16){lat_sign & shifted[15]}}, shifted};
            default: load_val = i_ram_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_sign    <= 1'b0;
            lat_rd_en   <= 1'b0;
            lat_rd      <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_mask    <= '0;
            o_wb_rd_en  <= 1'b0;
            o_wb_rd     <= '0;
            o_wb_rd_reg <= '0;
`ifdef NNRV_MEM_TIMEOUT_EN
            tcnt        <= '0;
            bus_err     <= 1'b0;
`endif
        end else begin
`ifdef NNRV_MEM_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        o_wb_rd_en  <= i_ex_rd_en;
                        o_wb_rd     <= i_ex_rd;
                        o_wb_rd_reg <= i_ex_rd_reg;
                    end else begin
                        o_wb_rd_en <= 1'b0;
                        if (req_hit) begin
                            lat_we    <= !i_ex_ram_rd_en;
                            lat_sign  <= i_ex_sign;
                            lat_rd_en <= i_ex_rd_en;
                            lat_rd    <= i_ex_rd;
                            lat_addr  <= i_ex_ram_addr[ADDR_WIDTH+1:2];
                            lat_data  <= i_ex_ram_data;
                            lat_mask  <= i_ex_ram_mask;
                            state     <= ACCESS;
`ifdef NNRV_MEM_TIMEOUT_EN
                            tcnt      <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (i_ram_ack) begin
                        state      <= IDLE;
                        o_wb_rd_en <= lat_rd_en && !lat_we;
                        o_wb_rd    <= lat_rd;
                        if (!lat_we)
                            o_wb_rd_reg <= load_val;
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        o_wb_rd_en <= lat_rd_en && !lat_we;
                        o_wb_rd    <= lat_rd;
                        if (!lat_we)
                            o_wb_rd_reg <= '0;
`ifdef NNRV_MEM_TIMEOUT_EN
                        bus_err    <= 1'b1;
`endif
                    end else begin
                        o_wb_rd_en <= 1'b0;
`ifdef NNRV_MEM_TIMEOUT_EN
                        tcnt       <= tcnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nnrv_mem_stage.sv
// tb/tb_nnrv_mem_stage.sv - scoreboard bench for nnrv_mem_stage with a randomized RAM responder.
module tb_nnrv_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_rd_en, ex_ram_rd_en, ex_ram_wr_en, ex_sign;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd_reg, ex_ram_addr, ex_ram_data;
    logic [3:0]  ex_ram_mask;
    logic        ex_stall, ram_req, ram_we, ram_ack;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        wb_rd_en, id_rd_ready, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_reg;

    always #5 clk = ~clk;

    nnrv_mem_stage dut (
        .i_clk(clk), .i_rst(rst),
        .i_ex_rd_en(ex_rd_en), .i_ex_rd(ex_rd), .i_ex_rd_reg(ex_rd_reg),
        .i_ex_ram_rd_en(ex_ram_rd_en), .i_ex_ram_wr_en(ex_ram_wr_en),
        .i_ex_ram_addr(ex_ram_addr), .i_ex_ram_data(ex_ram_data),
        .i_ex_ram_mask(ex_ram_mask), .i_ex_sign(ex_sign),
        .o_ex_stall(ex_stall), .o_ram_req(ram_req), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_be(ram_be),
        .i_ram_ack(ram_ack), .i_ram_rdata(ram_rdata),
        .o_wb_rd_en(wb_rd_en), .o_wb_rd(wb_rd), .o_wb_rd_reg(wb_rd_reg),
        .o_id_rd_ready(id_rd_ready), .o_bus_err(bus_err)
    );

    typedef struct {logic [4:0] rd; logic [31:0] val;} wb_t;
    typedef struct {logic we; logic [7:0] addr; logic [31:0] wdata; logic [3:0] be;} rq_t;

    wb_t         wb_q[$];
    rq_t         rq_q[$];
    logic [31:0] ram   [256];
    logic [31:0] model [256];
    int          errors = 0;
    int          checks = 0;
    int          force_delay = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Load result from the mask rules: lowest enabled byte is the field start.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [3:0] mask, input bit sign);
        int          lane;
        int          n;
        logic [31:0] sh;
        lane = 0;
        n = 0;
        for (int i = 3; i >= 0; i--) if (mask[i]) lane = i;
        for (int i = 0; i < 4; i++) n += int'(mask[i]);
        sh = word >> (8 * lane);
        if (n == 1)
            return sign ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        if (mask == 4'b0011 || mask == 4'b0110 || mask == 4'b1100)
            return sign ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        return word;
    endfunction

    // RAM responder: random (or forced) ack delay, plus spurious acks while idle.
    initial begin
        int  wait_cnt;
        bit  busy;
        busy = 0;
        wait_cnt = 0;
        ram_ack = 1'b0;
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            ram_ack = 1'b0;
            if (ram_req) begin
                if (!busy) begin
                    busy = 1;
                    wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                end
                if (wait_cnt == 0) begin
                    ram_ack = 1'b1;
                    busy = 0;
                    if (ram_we) begin
                        for (int b = 0; b < 4; b++)
                            if (ram_be[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
                        ram_rdata = $urandom;
                    end else begin
                        ram_rdata = ram[ram_addr];
                    end
                end else begin
                    wait_cnt--;
                    ram_rdata = $urandom;
                end
            end else begin
                busy = 0;
                ram_ack = ($urandom_range(0, 3) == 0);
                ram_rdata = $urandom;
            end
        end
    end

    // Monitor: pops expected writebacks and RAM requests as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_rd_en) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got rd=%0d data=%h expected none", wb_rd, wb_rd_reg);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_rd_reg", wb_rd_reg, e.val);
                    chk("id_rd_ready", 32'(id_rd_ready), 32'd1);
                end
            end
            if (ram_req) begin
                if (rq_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr=%h expected no request", ram_addr);
                end else begin
                    rq_t r;
                    r = rq_q[0];
                    chk("ram_we", 32'(ram_we), 32'(r.we));
                    chk("ram_addr", 32'(ram_addr), 32'(r.addr));
                    chk("ram_wdata", ram_wdata, r.wdata);
                    chk("ram_be", 32'(ram_be), 32'(r.be));
                    chk("stall_access", 32'(ex_stall), 32'(!ram_ack));
                    if (ram_ack) void'(rq_q.pop_front());
                end
            end
            chk("bus_err", 32'(bus_err), 32'd0);
        end
    end

    task automatic issue(input bit rd_en, input logic [4:0] rd, input logic [31:0] rd_reg,
                         input bit lr, input bit sr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input bit sign, input bit use_exp, input logic [31:0] exp_val);
        bit   mem;
        bit   act;
        int   idx;
        int   n;
        mem = lr | sr;
        act = mem && (mask != 4'b0000);
        idx = int'(addr[9:2]);
        if (!mem && rd_en) wb_q.push_back('{rd, rd_reg});
        if (act) begin
            rq_q.push_back('{!lr, addr[9:2], data, mask});
            if (lr) begin
                if (rd_en) wb_q.push_back('{rd, use_exp ? exp_val : ref_load(model[idx], mask, sign)});
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        ex_rd_en = rd_en; ex_rd = rd; ex_rd_reg = rd_reg;
        ex_ram_rd_en = lr; ex_ram_wr_en = sr; ex_ram_addr = addr;
        ex_ram_data = data; ex_ram_mask = mask; ex_sign = sign;
        @(negedge clk);
        chk("stall_first", 32'(ex_stall), 32'(act));
        n = 0;
        while (ex_stall) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL stall_bound: got stall still high expected release within 60 cycles");
                finish_run();
            end
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ex_rd_en = 0; ex_rd = '0; ex_rd_reg = '0; ex_ram_rd_en = 0; ex_ram_wr_en = 0;
        ex_ram_addr = '0; ex_ram_data = '0; ex_ram_mask = '0; ex_sign = 0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            model[i] = ram[i];
        end
        ram[3] = 32'h0000_8000;   model[3] = 32'h0000_8000;
        ram[0] = 32'hBEEF_0000;   model[0] = 32'hBEEF_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_rd_en", 32'(wb_rd_en), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_rd_reg", wb_rd_reg, 0);
        chk("rst_ram_req", 32'(ram_req), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_be", 32'(ram_be), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_id_rd_ready", 32'(id_rd_ready), 0);
        chk("rst_stall", 32'(ex_stall), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        issue(1, 5'd5, 32'h1234, 0, 0, '0, '0, 4'b0000, 0, 0, '0);
        force_delay = 0;
        issue(1, 5'd7, 32'h0, 1, 0, 32'h0D, '0, 4'b0010, 1, 1, 32'hFFFF_FF80);
        issue(1, 5'd8, 32'h0, 1, 0, 32'h02, '0, 4'b1100, 0, 1, 32'h0000_BEEF);
        force_delay = 3;
        issue(1, 5'd9, 32'h0, 0, 1, 32'h10, 32'hCAFE_BABE, 4'b1111, 0, 0, '0);
        force_delay = -1;
        issue(1, 5'd10, 32'h0, 1, 0, 32'h10, '0, 4'b1111, 1, 1, 32'hCAFE_BABE);
        issue(1, 5'd11, 32'h5555, 1, 0, 32'h20, '0, 4'b0000, 0, 0, '0);
        issue(1, 5'd0, 32'h0, 1, 1, 32'h0D, 32'h1111_1111, 4'b0001, 1, 0, '0);
        issue(0, 5'd12, 32'h7777, 0, 0, '0, '0, 4'b0000, 0, 0, '0);

        // Reset while the RAM transaction is outstanding.
        force_delay = 1000;
        ex_rd_en = 1; ex_rd = 5'd13; ex_ram_rd_en = 1; ex_ram_wr_en = 0;
        ex_ram_addr = 32'h44; ex_ram_mask = 4'b1111; ex_sign = 0;
        rq_q.push_back('{1'b0, 8'h11, ex_ram_data, 4'b1111});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ram_req && n < 10);
        chk("rst_access_entered", 32'(ram_req), 1);
        rst = 1'b1;
        ex_rd_en = 0; ex_ram_rd_en = 0; ex_ram_mask = '0;
        @(negedge clk);
        chk("rst_access_req", 32'(ram_req), 0);
        chk("rst_access_wb", 32'(wb_rd_en), 0);
        chk("rst_access_stall", 32'(ex_stall), 0);
        rst = 1'b0;
        if (rq_q.size() > 0) void'(rq_q.pop_front());
        force_delay = -1;
        @(posedge clk);
        #2;

        for (int t = 0; t < 300; t++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            a = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
            issue(1'($urandom), 5'($urandom), $urandom, kind == 1 || kind == 3, kind >= 2,
                  a, $urandom, 4'($urandom), 1'($urandom), 0, '0);
        end

        ex_rd_en = 0; ex_ram_rd_en = 0; ex_ram_wr_en = 0; ex_ram_mask = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wb_queue_drained", 32'(wb_q.size()), 0);
        chk("req_queue_drained", 32'(rq_q.size()), 0);
        finish_run();
    end
endmodule
